alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters (e.g. datapath issue slot and address-generation slot).
- Uses a valid/ready request handshake and a held valid/ready response per requester.
- Arbitration is round-robin; one operation is in flight at a time.
- Operands are registered before the ALU and the result is registered after it, so the ALU's combinational path is isolated from requester logic.

Parameters:
- WIDTH, 32, operand/result width; passed to the `alu` instance.

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  synchronous reset, active-high
- REQ0_VALID / REQ1_VALID  in  1  requester i presents an operation
- REQ0_READY / REQ1_READY  out  1  requester i's operation accepted this cycle
- REQ0_A / REQ1_A  in  WIDTH  operand A
- REQ0_B / REQ1_B  in  WIDTH  operand B
- REQ0_OP / REQ1_OP  in  4  ALU operation code
- RSP0_VALID / RSP1_VALID  out  1  result for requester i available
- RSP0_READY / RSP1_READY  in  1  requester i consumes result
- RSP0_RESULT / RSP1_RESULT  out  WIDTH  result
- RSP0_ILLEGAL / RSP1_ILLEGAL  out  1  opcode was not AND/OR/ADD/SUB
- BUSY  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock CLK; RST synchronous, active-high.
- Reset values: state=IDLE, LAST_GRANT=1 (requester 0 wins first), operand/result/illegal registers=0, all REQx_READY=0, RSPx_VALID=0, BUSY=0.
- State IDLE:
  - Grant = the only valid requester; if both are valid, the one != LAST_GRANT.
  - REQi_READY=1 combinationally for the granted i only; never both.
  - On handshake: latch A, B, OP, owner=i; LAST_GRANT<=i; go to EXEC.
  - No valid requester: stay in IDLE.
- State EXEC (1 cycle):
  - ALU sees the latched operands.
  - Latch RESULT<=ALU_RESULT and ILLEGAL<=(OP not in {0000,0001,0010,0110}).
  - Go to RESP.
- State RESP:
  - RSP<owner>_VALID=1; the other RSP_VALID=0.
  - RSP<owner>_RESULT and ILLEGAL are held stable until RSP<owner>_READY=1.
  - On that cycle go to IDLE.
  - RSP_READY of the non-owner is ignored.
- RSPx_RESULT/ILLEGAL show the shared result registers for both requesters; they are meaningful only while the matching RSP_VALID=1.
- Timing:
  - Latency: request handshake at cycle t gives RSP_VALID at t+2.
  - Peak throughput: one op per 3 cycles when RSP_READY is tied high.
  - No REQ_READY outside IDLE.
- Arithmetic: per the ALU, mod 2^WIDTH; SUB wraps (3-5 = all-ones minus 1). An illegal opcode yields all-ones and ILLEGAL=1, with no other side effect.
- Requester rules:
  - A requester may deassert VALID before READY; no request is latched in that case.
  - Inputs are sampled only on the handshake cycle.
- Fairness: a requester held valid is served within at most 2 grants.
- RST in any state (including EXEC/RESP): the in-flight op is discarded, no response is produced, LAST_GRANT returns to 1.
- Simultaneous RSP_READY on the handshake into RESP is not possible; RSP_VALID is first high in RESP.

Decomposition:
- Package `alu_pkg`:
  - Opcode constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110.
  - State enum {IDLE, EXEC, RESP}.
  - Function is_legal_op(op).
- Sub-modules: instantiates existing `alu` (WIDTH passed through); no other sub-module.
- Arbitration logic stays inline; it is under 20 lines.

Test Plan:
- After reset, REQ0 ADD A=5,B=7, RSP0_READY=1 -> REQ0_READY at t, RSP0_VALID at t+2 with RESULT=12, ILLEGAL=0, BUSY high t+1..t+2.
- Both requesters valid continuously after reset:
  - Stimulus: REQ0 SUB 3-5, REQ1 OR 0xF0|0x0F.
  - Required: grants are 0,1,0,1; RSP0=0xFFFFFFFE, RSP1=0x000000FF; each response reaches only its owner.
- Backpressure: RSP1_READY low 4 cycles in RESP -> RSP1_VALID/RESULT held stable, no REQ_READY to either requester until the consume cycle, then IDLE.
- REQ0 OP=4'b1111 -> RSP0_RESULT=0xFFFFFFFF, RSP0_ILLEGAL=1; the following legal AND 0xFF00&0x0FF0 -> 0x0F00, ILLEGAL=0.
- RST asserted during EXEC and during RESP -> next cycle all outputs at reset values, no RSP_VALID ever produced for the dropped op; both requesters then valid -> requester 0 granted.
- REQ1 asserts VALID one cycle then drops while the block is in RESP -> no handshake, no response for REQ1, BUSY low after the current op.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and opcode legality helper for the shared ALU arbiter
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU; unknown opcodes produce all-ones
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = '1;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      default: result = '1;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one registered-in/registered-out ALU between two requesters
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic [3:0]       REQ0_OP,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  input  logic [3:0]       REQ1_OP,
  output logic             RSP0_VALID,
  input  logic             RSP0_READY,
  output logic [WIDTH-1:0] RSP0_RESULT,
  output logic             RSP0_ILLEGAL,
  output logic             RSP1_VALID,
  input  logic             RSP1_READY,
  output logic [WIDTH-1:0] RSP1_RESULT,
  output logic             RSP1_ILLEGAL,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_result;
  logic             grant_valid;
  logic             grant_sel;
  logic             owner_rsp_ready;

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result)
  );

  // Contended grants go to whoever did not win last; RST masks grants so no handshake is claimed.
  always_comb begin
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    if (state_q == IDLE && !RST) begin
      if (REQ0_VALID && REQ1_VALID) begin
        grant_valid = 1'b1;
        grant_sel   = ~last_grant_q;
      end else if (REQ0_VALID) begin
        grant_valid = 1'b1;
        grant_sel   = 1'b0;
      end else if (REQ1_VALID) begin
        grant_valid = 1'b1;
        grant_sel   = 1'b1;
      end
    end
  end

  assign REQ0_READY = grant_valid && !grant_sel;
  assign REQ1_READY = grant_valid && grant_sel;

  assign owner_rsp_ready = owner_q ? RSP1_READY : RSP0_READY;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    illegal_d    = illegal_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d      = grant_sel;
          last_grant_d = grant_sel;
          a_d          = grant_sel ? REQ1_A  : REQ0_A;
          b_d          = grant_sel ? REQ1_B  : REQ0_B;
          op_d         = grant_sel ? REQ1_OP : REQ0_OP;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d  = alu_result;
        illegal_d = !is_legal_op(op_q);
        state_d   = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      illegal_q    <= illegal_d;
    end
  end

  // Both requesters see the shared result registers; only RSPx_VALID qualifies them.
  assign RSP0_VALID   = (state_q == RESP) && !owner_q;
  assign RSP1_VALID   = (state_q == RESP) && owner_q;
  assign RSP0_RESULT  = result_q;
  assign RSP1_RESULT  = result_q;
  assign RSP0_ILLEGAL = illegal_q;
  assign RSP1_ILLEGAL = illegal_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter
module tb_alu_arbiter;

  localparam int W = 32;

  logic         CLK, RST;
  logic         REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [W-1:0] REQ0_A, REQ0_B, REQ1_A, REQ1_B;
  logic [3:0]   REQ0_OP, REQ1_OP;
  logic         RSP0_VALID, RSP0_READY, RSP0_ILLEGAL;
  logic         RSP1_VALID, RSP1_READY, RSP1_ILLEGAL;
  logic [W-1:0] RSP0_RESULT, RSP1_RESULT;
  logic         BUSY;

  alu_arbiter #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_OP(REQ0_OP),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_OP(REQ1_OP),
    .RSP0_VALID(RSP0_VALID), .RSP0_READY(RSP0_READY), .RSP0_RESULT(RSP0_RESULT), .RSP0_ILLEGAL(RSP0_ILLEGAL),
    .RSP1_VALID(RSP1_VALID), .RSP1_READY(RSP1_READY), .RSP1_RESULT(RSP1_RESULT), .RSP1_ILLEGAL(RSP1_ILLEGAL),
    .BUSY(BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int         owner;
    logic [W-1:0] res;
    logic       ill;
  } exp_t;

  exp_t         sb[$];
  int           grant_log[$];
  int           err_cnt = 0;
  int           chk_cnt = 0;
  int           rsp_cnt[2];
  logic [W-1:0] last_res[2];
  logic         last_ill[2];
  int           m_state = 0;
  int           m_last = 1;
  int           m_owner = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return {W{1'b1}};
    endcase
  endfunction

  function automatic logic ref_ill(input logic [3:0] op);
    return !(op == 4'b0000 || op == 4'b0001 || op == 4'b0010 || op == 4'b0110);
  endfunction

  // Reference model: evaluated between edges, advanced to represent the coming rising edge.
  always @(negedge CLK) begin : monitor
    int   g;
    exp_t e;
    g = -1;
    if (!RST && m_state == 0) begin
      if (REQ0_VALID && REQ1_VALID) g = (m_last == 0) ? 1 : 0;
      else if (REQ0_VALID) g = 0;
      else if (REQ1_VALID) g = 1;
    end
    check_eq("req0_ready", 64'(REQ0_READY), 64'(g == 0));
    check_eq("req1_ready", 64'(REQ1_READY), 64'(g == 1));
    check_eq("busy", 64'(BUSY), 64'(m_state != 0));
    check_eq("rsp0_valid", 64'(RSP0_VALID), 64'(m_state == 2 && m_owner == 0));
    check_eq("rsp1_valid", 64'(RSP1_VALID), 64'(m_state == 2 && m_owner == 1));
    if (m_state == 2) begin
      check_eq("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        check_eq("rsp_result", 64'(m_owner == 1 ? RSP1_RESULT : RSP0_RESULT), 64'(e.res));
        check_eq("rsp_illegal", 64'(m_owner == 1 ? RSP1_ILLEGAL : RSP0_ILLEGAL), 64'(e.ill));
      end
    end
    if (RST) begin
      m_state = 0;
      m_last  = 1;
      sb.delete();
    end else begin
      case (m_state)
        0: if (g >= 0) begin
          e.owner = g;
          e.res   = (g == 1) ? ref_alu(REQ1_A, REQ1_B, REQ1_OP) : ref_alu(REQ0_A, REQ0_B, REQ0_OP);
          e.ill   = (g == 1) ? ref_ill(REQ1_OP) : ref_ill(REQ0_OP);
          sb.push_back(e);
          grant_log.push_back(g);
          m_last  = g;
          m_owner = g;
          m_state = 1;
        end
        1: m_state = 2;
        default: if ((m_owner == 0 && RSP0_READY) || (m_owner == 1 && RSP1_READY)) begin
          if (sb.size() != 0) void'(sb.pop_front());
          rsp_cnt[m_owner]++;
          last_res[m_owner] = (m_owner == 1) ? RSP1_RESULT : RSP0_RESULT;
          last_ill[m_owner] = (m_owner == 1) ? RSP1_ILLEGAL : RSP0_ILLEGAL;
          m_state = 0;
        end
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ0_VALID = 0;
    REQ1_VALID = 0;
    RST = 1;
    tick(1);
    RST = 0;
    #1;
    check_eq("rst_busy", 64'(BUSY), 0);
    check_eq("rst_rsp0_valid", 64'(RSP0_VALID), 0);
    check_eq("rst_rsp1_valid", 64'(RSP1_VALID), 0);
    check_eq("rst_result", 64'(RSP0_RESULT), 0);
    check_eq("rst_illegal", 64'(RSP1_ILLEGAL), 0);
    check_eq("rst_req0_ready", 64'(REQ0_READY), 0);
  endtask

  task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    bit ok;
    if (r == 0) begin REQ0_A = a; REQ0_B = b; REQ0_OP = op; REQ0_VALID = 1; RSP0_READY = 1; end
    else        begin REQ1_A = a; REQ1_B = b; REQ1_OP = op; REQ1_VALID = 1; RSP1_READY = 1; end
    #1;
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin
      if ((r == 0 && REQ0_READY) || (r == 1 && REQ1_READY)) ok = 1;
      tick(1);
    end
    check_eq("run_op_grant", 64'(ok), 1);
    if (r == 0) REQ0_VALID = 0; else REQ1_VALID = 0;
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin
      if ((r == 0 && RSP0_VALID) || (r == 1 && RSP1_VALID)) ok = 1;
      tick(1);
    end
    check_eq("run_op_rsp", 64'(ok), 1);
  endtask

  initial begin
    int c0, c1;
    RST = 1; REQ0_VALID = 0; REQ1_VALID = 0; RSP0_READY = 0; RSP1_READY = 0;
    REQ0_A = 0; REQ0_B = 0; REQ0_OP = 0; REQ1_A = 0; REQ1_B = 0; REQ1_OP = 0;
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    tick(2);
    do_reset();

    // Single ADD: latency and BUSY window
    REQ0_A = 5; REQ0_B = 7; REQ0_OP = 4'b0010; REQ0_VALID = 1; RSP0_READY = 1;
    #1;
    check_eq("add_req0_ready", 64'(REQ0_READY), 1);
    tick(1);
    REQ0_VALID = 0;
    #1;
    check_eq("add_busy_t1", 64'(BUSY), 1);
    check_eq("add_rsp_t1", 64'(RSP0_VALID), 0);
    tick(1);
    check_eq("add_rsp_t2", 64'(RSP0_VALID), 1);
    check_eq("add_result", 64'(RSP0_RESULT), 12);
    check_eq("add_illegal", 64'(RSP0_ILLEGAL), 0);
    check_eq("add_busy_t2", 64'(BUSY), 1);
    tick(1);
    check_eq("add_busy_t3", 64'(BUSY), 0);

    // Both requesters contending continuously
    do_reset();
    grant_log.delete();
    c0 = rsp_cnt[0]; c1 = rsp_cnt[1];
    REQ0_A = 3; REQ0_B = 5; REQ0_OP = 4'b0110;
    REQ1_A = 32'hF0; REQ1_B = 32'h0F; REQ1_OP = 4'b0001;
    REQ0_VALID = 1; REQ1_VALID = 1; RSP0_READY = 1; RSP1_READY = 1;
    tick(12);
    REQ0_VALID = 0; REQ1_VALID = 0;
    check_eq("rr_count", 64'(grant_log.size()), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check_eq($sformatf("rr_grant%0d", i), 64'(grant_log[i]), 64'(i % 2));
    check_eq("rr_rsp0", 64'(last_res[0]), 64'hFFFF_FFFE);
    check_eq("rr_rsp1", 64'(last_res[1]), 64'h0000_00FF);
    check_eq("rr_cnt0", 64'(rsp_cnt[0] - c0), 2);
    check_eq("rr_cnt1", 64'(rsp_cnt[1] - c1), 2);

    // Backpressure on RSP1 while REQ0 waits
    REQ1_A = 32'h10; REQ1_B = 32'h20; REQ1_OP = 4'b0010; REQ1_VALID = 1; RSP1_READY = 0; RSP0_READY = 1;
    #1;
    check_eq("bp_req1_ready", 64'(REQ1_READY), 1);
    tick(1);
    REQ1_VALID = 0;
    REQ0_A = 32'hF0F0; REQ0_B = 32'hFF00; REQ0_OP = 4'b0000; REQ0_VALID = 1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp_rsp1_valid", 64'(RSP1_VALID), 1);
      check_eq("bp_rsp1_result", 64'(RSP1_RESULT), 64'h30);
      check_eq("bp_req0_blocked", 64'(REQ0_READY), 0);
      tick(1);
    end
    RSP1_READY = 1;
    #1;
    check_eq("bp_consume_req0", 64'(REQ0_READY), 0);
    check_eq("bp_consume_valid", 64'(RSP1_VALID), 1);
    tick(1);
    check_eq("bp_idle_busy", 64'(BUSY), 0);
    check_eq("bp_idle_req0", 64'(REQ0_READY), 1);
    tick(1);
    REQ0_VALID = 0;
    tick(3);
    check_eq("bp_and_result", 64'(last_res[0]), 64'hF000);

    // Illegal opcode then legal AND
    run_op(0, 32'h1234, 32'h5678, 4'b1111);
    check_eq("ill_result", 64'(last_res[0]), 64'hFFFF_FFFF);
    check_eq("ill_flag", 64'(last_ill[0]), 1);
    run_op(0, 32'hFF00, 32'h0FF0, 4'b0000);
    check_eq("and_result", 64'(last_res[0]), 64'h0F00);
    check_eq("and_flag", 64'(last_ill[0]), 0);

    // Reset during EXEC
    c0 = rsp_cnt[0];
    REQ0_A = 1; REQ0_B = 1; REQ0_OP = 4'b0010; REQ0_VALID = 1; RSP0_READY = 1;
    tick(1);
    do_reset();
    tick(4);
    check_eq("rst_exec_no_rsp", 64'(rsp_cnt[0] - c0), 0);

    // Reset during RESP, then contention must favour requester 0
    REQ0_VALID = 1; RSP0_READY = 0;
    tick(1);
    REQ0_VALID = 0;
    tick(1);
    check_eq("rst_resp_pre", 64'(RSP0_VALID), 1);
    do_reset();
    tick(3);
    check_eq("rst_resp_no_rsp", 64'(rsp_cnt[0] - c0), 0);
    REQ0_VALID = 1; REQ1_VALID = 1; RSP0_READY = 1; RSP1_READY = 1;
    #1;
    check_eq("post_rst_req0", 64'(REQ0_READY), 1);
    check_eq("post_rst_req1", 64'(REQ1_READY), 0);
    tick(1);
    REQ0_VALID = 0; REQ1_VALID = 0;
    tick(3);

    // REQ1 pulses VALID while the block is in RESP
    c1 = rsp_cnt[1];
    REQ0_A = 2; REQ0_B = 3; REQ0_OP = 4'b0010; REQ0_VALID = 1; RSP0_READY = 0;
    tick(1);
    REQ0_VALID = 0;
    tick(2);
    REQ1_VALID = 1;
    tick(1);
    REQ1_VALID = 0; RSP0_READY = 1;
    tick(1);
    check_eq("pulse_busy_now", 64'(BUSY), 0);
    tick(3);
    check_eq("pulse_busy_later", 64'(BUSY), 0);
    check_eq("pulse_no_rsp1", 64'(rsp_cnt[1] - c1), 0);
    check_eq("pulse_rsp0", 64'(last_res[0]), 5);

    check_eq("sb_drained", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
